// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: debounced-button RUN/PAUSE controller driving a 16-LED one-hot rotator.
// Optional macro LED_SEQ_STEP_EN compiles in single-step support (btn_step debouncer).

module led_seq_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 100_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    output logic press
);
    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic             level_d_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchronize the raw button and accept a new level only after it has been stable long enough
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r   <= 1'b0;
            sync2_r   <= 1'b0;
            level_r   <= 1'b0;
            level_d_r <= 1'b0;
            cnt_r     <= '0;
        end else begin
            sync1_r   <= btn;
            sync2_r   <= sync1_r;
            level_d_r <= level_r;
            if (sync2_r != level_r) begin
                if (cnt_r == CNT_LAST) begin
                    level_r <= sync2_r;
                    cnt_r   <= '0;
                end else begin
                    cnt_r <= cnt_r + CNT_ONE;
                end
            end else begin
                cnt_r <= '0;
            end
        end
    end

    // Only the debounced rising edge is an event; releases are silent
    assign press = level_r & ~level_d_r;
endmodule

module led_seq_ctrl #(
    parameter int unsigned BASE_DIV        = 10_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 100_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        btn_run,
    input  logic        btn_dir,
    input  logic        btn_step,
    input  logic        btn_speed,
    output logic [15:0] led_out,
    output logic [1:0]  state_out,
    output logic        dir_out,
    output logic [1:0]  speed_out,
    output logic        tick
);
    localparam int unsigned      PRE_W   = $clog2(BASE_DIV + 1);
    localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_e;

    state_e             state_r;
    state_e             state_nxt_s;
    logic [15:0]        led_r;
    logic [15:0]        led_nxt_s;
    logic               dir_r;
    logic               dir_nxt_s;
    logic [1:0]         speed_r;
    logic [1:0]         speed_nxt_s;
    logic               tick_r;
    logic               tick_nxt_s;
    logic [PRE_W-1:0]   presc_r;
    logic [PRE_W-1:0]   presc_nxt_s;
    logic [PRE_W-1:0]   period_s;
    logic               terminal_s;
    logic               run_press_s;
    logic               dir_press_s;
    logic               step_press_s;
    logic               speed_press_s;

    function automatic logic [15:0] rotate(input logic [15:0] v, input logic right);
        logic [15:0] r;
        if (right) begin
            r = {v[0], v[15:1]};
        end else begin
            r = {v[14:0], v[15]};
        end
        return r;
    endfunction

    led_seq_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
        .clk(clk), .reset_n(reset_n), .btn(btn_run), .press(run_press_s)
    );
    led_seq_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dir (
        .clk(clk), .reset_n(reset_n), .btn(btn_dir), .press(dir_press_s)
    );
    led_seq_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_speed (
        .clk(clk), .reset_n(reset_n), .btn(btn_speed), .press(speed_press_s)
    );

`ifdef LED_SEQ_STEP_EN
    led_seq_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
        .clk(clk), .reset_n(reset_n), .btn(btn_step), .press(step_press_s)
    );
`else
    logic unused_step_s;
    assign unused_step_s = btn_step;
    assign step_press_s  = 1'b0;
`endif

    // Each speed step halves the tick period
    assign period_s   = PRE_W'(BASE_DIV) >> speed_r;
    assign terminal_s = (presc_r == (period_s - PRE_ONE));

    // Next-state, rotation, prescaler and control-register updates
    always_comb begin
        state_nxt_s = state_r;
        led_nxt_s   = led_r;
        dir_nxt_s   = dir_r;
        speed_nxt_s = speed_r;
        tick_nxt_s  = 1'b0;
        presc_nxt_s = presc_r;
        case (state_r)
            ST_IDLE: begin
                if (run_press_s) begin
                    state_nxt_s = ST_RUN;
                    led_nxt_s   = 16'h0001;
                    presc_nxt_s = '0;
                end else begin
                    led_nxt_s   = 16'h0000;
                end
            end
            ST_RUN: begin
                if (terminal_s) begin
                    tick_nxt_s  = 1'b1;
                    led_nxt_s   = rotate(led_r, dir_r);
                    presc_nxt_s = '0;
                end else begin
                    presc_nxt_s = presc_r + PRE_ONE;
                end
                if (run_press_s) begin
                    state_nxt_s = ST_PAUSE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_PAUSE: begin
                // A run press outranks a simultaneous step
                if (run_press_s) begin
                    state_nxt_s = ST_RUN;
                    presc_nxt_s = '0;
                end else if (step_press_s) begin
                    led_nxt_s   = rotate(led_r, dir_r);
                end else begin
                    led_nxt_s   = led_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                led_nxt_s   = 16'h0000;
                presc_nxt_s = '0;
            end
        endcase
        if (dir_press_s) begin
            dir_nxt_s = ~dir_r;
        end else begin
            dir_nxt_s = dir_r;
        end
        if (speed_press_s) begin
            speed_nxt_s = speed_r + 2'd1;
            presc_nxt_s = '0;
        end else begin
            speed_nxt_s = speed_r;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_r   <= 16'h0000;
            dir_r   <= 1'b0;
            speed_r <= 2'b00;
            tick_r  <= 1'b0;
            presc_r <= '0;
        end else begin
            led_r   <= led_nxt_s;
            dir_r   <= dir_nxt_s;
            speed_r <= speed_nxt_s;
            tick_r  <= tick_nxt_s;
            presc_r <= presc_nxt_s;
        end
    end

    assign led_out   = led_r;
    assign state_out = state_r;
    assign dir_out   = dir_r;
    assign speed_out = speed_r;
    assign tick      = tick_r;
endmodule

// File: doc/led_seq_ctrl.md
# led_seq_ctrl

Run-time controller for the 16-LED rotator on the 10 MHz MMCM clock domain. It debounces three push-buttons and runs a RUN/PAUSE state machine with a programmable-rate tick prescaler. It owns the rotating one-hot LED register, so the rotator's speed, direction and single-stepping are set by user input instead of a fixed 1 Hz. It sits between the board buttons and `led[15:0]`, clocked by the MMCM output with the MMCM `locked` signal as reset.

## Interface
- `BASE_DIV`, 10_000_000: clock cycles per tick at speed 0 (1 Hz at 10 MHz); must be a multiple of 8.
- `DEBOUNCE_CYCLES`, 100_000: consecutive stable cycles required before a button level is accepted (10 ms).
- `clk`  in  1  system clock (10 MHz).
- `reset_n`  in  1  asynchronous, active-low reset.
- `btn_run`  in  1  raw button, asynchronous to `clk`; press toggles RUN/PAUSE and starts from IDLE.
- `btn_dir`  in  1  raw button; press toggles rotate direction.
- `btn_step`  in  1  raw button; press advances one position while paused.
- `btn_speed`  in  1  raw button; press cycles speed 0→1→2→3→0.
- `led_out`  out  16  one-hot LED pattern.
- `state_out`  out  2  00 IDLE, 01 RUN, 10 PAUSE.
- `dir_out`  out  1  0 = left (toward bit 15), 1 = right.
- `speed_out`  out  2  current speed select.
- `tick`  out  1  one-cycle pulse on each automatic rotation.

## Operation
- Per button: 2-flop synchronizer, then debounce counter.
  - Debounced level changes only after the synchronized input differs from it for `DEBOUNCE_CYCLES` consecutive cycles.
  - Any bounce clears the counter.
  - A press event is a 1-cycle pulse on the debounced rising edge. Releases generate nothing.
- FSM:
  - IDLE: `led_out`=0x0000. A run press loads 0x0001, clears the prescaler and goes to RUN.
  - RUN: a run press goes to PAUSE. The pattern is held.
  - PAUSE: a run press clears the prescaler and goes to RUN. A step press rotates one position in `dir_out` direction.
  - Step presses in IDLE or RUN are ignored.
- Prescaler:
  - Period P = `BASE_DIV` >> `speed_out` (1/2/4/8 Hz at defaults).
  - Counts 0..P-1 only in RUN. At P-1, `tick` is asserted and the counter returns to 0.
  - A speed press clears the prescaler in the same cycle.
- Rotation on `tick` or an accepted step:
  - Left: {led[14:0],led[15]}. Right: {led[0],led[15:1]}.
  - Wraps 0x8000→0x0001 (left) and 0x0001→0x8000 (right).
- A dir press toggles `dir_out` in any state, including IDLE. A speed press advances `speed_out` modulo 4 in any state.
- Simultaneous events in one cycle:
  - The rotation uses the pre-update `dir_out`.
  - A run press and a step press together in PAUSE: the run press wins and the step is dropped.
  - A speed press coincident with the prescaler terminal count: the tick fires, and the new period starts from 0.

## Timing
- Reset values: `led_out`=0x0000, `state_out`=00, `dir_out`=0, `speed_out`=00, `tick`=0. Synchronizers, debounce counters and the prescaler are all cleared.
- Reset assertion is asynchronous and takes effect immediately, including mid-RUN or mid-debounce.
- All outputs are registered.
- Button-to-event latency: 2 sync cycles + `DEBOUNCE_CYCLES` + 1 edge cycle.
- Event-to-output latency: 1 cycle (`state_out`, `dir_out`, `speed_out`, `led_out` on a step).
- First `tick` arrives P cycles after the RUN entry. `led_out` updates in the same cycle that `tick` is high.

## Configuration
- `LED_SEQ_STEP_EN` defined:
  - Step logic, including the `btn_step` debouncer, is compiled in and behaves as above.
- `LED_SEQ_STEP_EN` undefined:
  - `btn_step` remains a port but is unused and has no synchronizer or debouncer.
  - PAUSE holds the pattern unconditionally.
  - All other behaviour is identical.

## Test plan
All scenarios use `BASE_DIV`=16 and `DEBOUNCE_CYCLES`=4.
- Reset, then a run press held 10 cycles → `state_out`=01 and `led_out`=0x0001 at cycle 7 after the press. `tick` every 16 cycles; `led_out` goes 0x0002, 0x0004, … and wraps 0x8000→0x0001.
- 3-cycle glitch on `btn_run`, then release → no event; `state_out` stays 00.
- RUN, then press speed twice → `speed_out`=10 and `tick` period 4 cycles. Four presses total → `speed_out`=00 and period back to 16.
- PAUSE with `led_out`=0x0001, dir press, step press → `dir_out`=1, then `led_out`=0x8000. Without `LED_SEQ_STEP_EN`, `led_out` stays 0x0001.
- Run and step presses in the same cycle while in PAUSE → `state_out`=01 and `led_out` unchanged that cycle.
- Assert `reset_n`=0 mid-RUN with `led_out`=0x0100 → all outputs at reset values immediately, with no clock edge needed.
